// File: rtl/sw_disp_pkg.sv
// Shared constants and types for the slide-switch display scheduler.
package sw_disp_pkg;

    localparam int unsigned NUM_SW = 10;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_e;

    // One-hot vector for a switch index.
    function automatic logic [NUM_SW-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_SW'(1) << idx;
    endfunction

endpackage

// File: rtl/sw_display_scheduler_priority_encoder.sv
// Highest-set-bit priority encoder; combinational outputs.
module priority_encoder #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    // Ascending scan: the last (highest) set bit wins.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (req[i]) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_display_scheduler.sv
// Round-robin time-share of one 7-seg digit among the slide switches:
// each active switch is shown for HOLD_CYCLES, then the next lower one (wrapping).
module sw_display_scheduler
    import sw_disp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    output logic [IDX_W-1:0]  hex_val,
    output logic              valid,
    output logic [NUM_SW-1:0] grant
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
    localparam int unsigned MSK_W = NUM_SW + 1;
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_SW);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  hex_val_q, hex_val_d;
    logic              valid_q, valid_d;
    logic [NUM_SW-1:0] grant_q, grant_d;
    logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SW-1:0] sync_d [SYNC_STAGES];

    logic [NUM_SW-1:0] req;
    logic [NUM_SW-1:0] masked_req;
    logic [IDX_W-1:0]  masked_idx, full_idx, pick;
    logic              masked_valid, pick_valid;
    logic              rotate, load, clear;

    // Switch synchroniser chain.
    always_comb begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = (i == 0) ? sw : sync_q[(i == 0) ? 0 : i - 1];
        end
    end

    assign req        = sync_q[SYNC_STAGES-1];
    assign masked_req = req & NUM_SW'((MSK_W'(1) << ptr_q) - MSK_W'(1));

    priority_encoder #(.WIDTH(NUM_SW), .IDX_W(IDX_W)) u_enc_masked (
        .req     (masked_req),
        .idx_c   (masked_idx),
        .valid_c (masked_valid)
    );

    priority_encoder #(.WIDTH(NUM_SW), .IDX_W(IDX_W)) u_enc_full (
        .req     (req),
        .idx_c   (full_idx),
        .valid_c (pick_valid)
    );

    assign pick = masked_valid ? masked_idx : full_idx;

    // Next-state: rotate on hold expiry or when the shown switch is released.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        load       = 1'b0;
        clear      = 1'b0;
        rotate     = (state_q == SHOW) &&
                     (!req[hex_val_q] || (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)));
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (rotate) begin
                    if (pick_valid) begin
                        load = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            ptr_d      = pick;
            hold_cnt_d = '0;
        end else if (clear) begin
            hold_cnt_d = '0;
        end
    end

    // Output next-values: change only on a new grant or a clear.
    always_comb begin
        hex_val_d = hex_val_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        if (load) begin
            hex_val_d = pick;
            valid_d   = 1'b1;
            grant_d   = idx_to_onehot(pick);
        end else if (clear) begin
            hex_val_d = '0;
            valid_d   = 1'b0;
            grant_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            ptr_q      <= PTR_RST;
            hex_val_q  <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
            hex_val_q  <= hex_val_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign hex_val = hex_val_q;
    assign valid   = valid_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_sw_display_scheduler.sv
// Directed table-driven bench for sw_display_scheduler (HOLD_CYCLES=4, SYNC_STAGES=2).
module tb_sw_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic [3:0] hex_val;
    logic       valid;
    logic [9:0] grant;

    int n_vec;
    int n_err;

    typedef struct {
        logic       rst_n;
        logic [9:0] sw;
        logic       exp_valid;
        logic [3:0] exp_hex;
    } vec_t;

    vec_t vecs[$];

    sw_display_scheduler #(.HOLD_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .hex_val (hex_val),
        .valid   (valid),
        .grant   (grant)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [9:0] s, input int n,
                       input logic v, input logic [3:0] h);
        vec_t e;
        e.rst_n     = r;
        e.sw        = s;
        e.exp_valid = v;
        e.exp_hex   = h;
        repeat (n) vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic v, input logic [3:0] h);
        logic [9:0] exp_grant;
        exp_grant = v ? (10'b1 << h) : 10'b0;
        n_vec++;
        if (valid !== v || hex_val !== h || grant !== exp_grant) begin
            n_err++;
            $display("FAIL %s @%0t: got valid=%b hex=%0d grant=%h, want valid=%b hex=%0d grant=%h",
                     name, $time, valid, hex_val, grant, v, h, exp_grant);
        end
    endtask

    // Drive each queued record for one clock, check just after the edge.
    task automatic run_vecs(input string tag);
        vec_t e;
        int   k;
        k = 0;
        while (vecs.size() > 0) begin
            e = vecs.pop_front();
            rst_n = e.rst_n;
            sw    = e.sw;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, k), e.exp_valid, e.exp_hex);
            k++;
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
        sw    = 10'h3FF;
        n_vec = 0;
        n_err = 0;
        #1 rst_n = 1'b0;
        #1 check("reset_async", 1'b0, 4'd0);

        // Reset held with all switches on, then single requester.
        add(1'b0, 10'h3FF, 3, 1'b0, 4'd0);
        add(1'b1, 10'h008, 2, 1'b0, 4'd0);
        add(1'b1, 10'h008, 20, 1'b1, 4'd3);
        add(1'b1, 10'h000, 2, 1'b1, 4'd3);
        add(1'b1, 10'h000, 2, 1'b0, 4'd0);
        // Rotation over 9,5,2 from a fresh reset.
        add(1'b0, 10'h3FF, 2, 1'b0, 4'd0);
        add(1'b1, 10'h224, 2, 1'b0, 4'd0);
        add(1'b1, 10'h224, 4, 1'b1, 4'd9);
        add(1'b1, 10'h224, 4, 1'b1, 4'd5);
        add(1'b1, 10'h224, 4, 1'b1, 4'd2);
        add(1'b1, 10'h224, 4, 1'b1, 4'd9);
        // Early release of 5 right as it is granted.
        add(1'b1, 10'h204, 2, 1'b1, 4'd5);
        add(1'b1, 10'h204, 4, 1'b1, 4'd2);
        add(1'b1, 10'h204, 4, 1'b1, 4'd9);
        add(1'b1, 10'h204, 4, 1'b1, 4'd2);
        // Idle gap after 5, pointer kept: 9,5 returns with 9 first.
        add(1'b1, 10'h220, 4, 1'b1, 4'd9);
        add(1'b1, 10'h000, 2, 1'b1, 4'd5);
        add(1'b1, 10'h000, 3, 1'b0, 4'd0);
        add(1'b1, 10'h220, 2, 1'b0, 4'd0);
        add(1'b1, 10'h220, 4, 1'b1, 4'd9);
        add(1'b1, 10'h220, 4, 1'b1, 4'd5);
        add(1'b1, 10'h220, 4, 1'b1, 4'd9);
        // Set up showing 2 for the async-reset case.
        add(1'b0, 10'h3FF, 1, 1'b0, 4'd0);
        add(1'b1, 10'h204, 2, 1'b0, 4'd0);
        add(1'b1, 10'h204, 4, 1'b1, 4'd9);
        add(1'b1, 10'h204, 1, 1'b1, 4'd2);
        run_vecs("tbl");

        // Async reset mid-cycle while showing 2.
        @(negedge clk);
        check("pre_async_rst", 1'b1, 4'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_mid", 1'b0, 4'd0);

        add(1'b0, 10'h204, 1, 1'b0, 4'd0);
        add(1'b1, 10'h204, 2, 1'b0, 4'd0);
        add(1'b1, 10'h204, 1, 1'b1, 4'd9);
        run_vecs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
